// File: rtl/rx_frame_fsm_pkg.sv
// Shared definitions for the UART receive path: frame state encodings,
// oversample count landmarks and framing-error levels. The byte-analysis
// stage imports this package as well, so the encodings must stay in step.
package rx_frame_fsm_pkg;

    // One-hot frame states, decoded directly by the downstream stages
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        STARTBIT  = 5'b00010,
        DATABITS  = 5'b00100,
        PARITYBIT = 5'b01000,
        STOPBIT   = 5'b10000
    } state_t;

    // Oversample position at which a bit is sampled (middle of the bit)
    localparam logic [3:0] ACQ_POINT = 4'd7;

    // Last oversample position of a bit; the next tick starts a new bit
    localparam logic [3:0] LAST_CNT = 4'd15;

    // Framing error levels
    typedef enum logic {
        RIGHT = 1'b0,
        WRONG = 1'b1
    } err_level_t;

endpackage

// File: rtl/rx_frame_fsm_if.sv
// Status bundle published by the receive frame FSM. The FSM drives it
// through the master modport; the shift-register and byte-analysis stages
// observe it through the slave modport.
interface rx_frame_fsm_if;

    logic [4:0] State_o;
    logic [3:0] BitWidthCnt_o;
    logic [2:0] BitCnt_o;
    logic       Bit_o;
    logic       p_BitValid_o;
    logic       p_FrameError_o;

    modport master (
        output State_o,
        output BitWidthCnt_o,
        output BitCnt_o,
        output Bit_o,
        output p_BitValid_o,
        output p_FrameError_o
    );

    modport slave (
        input State_o,
        input BitWidthCnt_o,
        input BitCnt_o,
        input Bit_o,
        input p_BitValid_o,
        input p_FrameError_o
    );

endinterface

// File: rtl/rx_line_sync.sv
// Brings the asynchronous serial line into the clk domain and flags the
// high-to-low transition that marks a potential start bit. All three flops
// reset to the idle-high line level so a reset never fakes a start edge.
module rx_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic line,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Two-stage synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign line = s2;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/rx_frame_fsm.sv
// Receive frame state machine: waits for a start edge, times every bit with
// the 16x oversample counter, samples the line mid-bit and walks through
// start, data, optional parity and stop bits. Every output is registered.
module rx_frame_fsm #(
    parameter int         DATA_BITS = 8,
    parameter logic [3:0] ACQ_POINT = rx_frame_fsm_pkg::ACQ_POINT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_i,
    input  logic          p_BaudTick_i,
    input  logic          p_ParityEnable_i,
    rx_frame_fsm_if.master bus
);

    import rx_frame_fsm_pkg::*;

    // Index of the final data bit, where the FSM decides parity or stop
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic       line;
    logic       fall;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic       bit_q;
    logic       bit_d;
    logic       valid_q;
    logic       valid_d;
    err_level_t ferr_q;
    err_level_t ferr_d;

    rx_line_sync u_line_sync (
        .clk  (clk),
        .rst  (rst),
        .rx_i (rx_i),
        .line (line),
        .fall (fall)
    );

    // State, counters and sampled-bit registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            bit_q     <= 1'b1;
            valid_q   <= 1'b0;
            ferr_q    <= RIGHT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic; counters only move on a baud tick so state and count
    // stay stable between ticks for the downstream decoders
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        bit_d     = bit_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                // A tick arriving together with the edge is swallowed here,
                // so the start bit always begins at count 0
                if (fall) begin
                    state_d = STARTBIT;
                    ferr_d  = RIGHT;
                end
            end

            STARTBIT, DATABITS, PARITYBIT, STOPBIT: begin
                if (p_BaudTick_i) begin
                    cnt_d = cnt_q + 4'd1;

                    if (cnt_q == ACQ_POINT) begin
                        bit_d   = line;
                        valid_d = 1'b1;
                        // Line back high mid start bit: glitch, not a frame
                        if ((state_q == STARTBIT) && line) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                        if ((state_q == STOPBIT) && !line) begin
                            ferr_d = WRONG;
                        end
                    end

                    if (cnt_q == LAST_CNT) begin
                        case (state_q)
                            STARTBIT: begin
                                state_d   = DATABITS;
                                bit_cnt_d = '0;
                            end
                            DATABITS: begin
                                if (bit_cnt_q == LAST_BIT) begin
                                    state_d = p_ParityEnable_i ? PARITYBIT : STOPBIT;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 3'd1;
                                end
                            end
                            PARITYBIT: begin
                                state_d = STOPBIT;
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign bus.State_o        = state_q;
    assign bus.BitWidthCnt_o  = cnt_q;
    assign bus.BitCnt_o       = bit_cnt_q;
    assign bus.Bit_o          = bit_q;
    assign bus.p_BitValid_o   = valid_q;
    assign bus.p_FrameError_o = ferr_q;

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Self-checking bench for rx_frame_fsm. Frames are described as a list of
// line levels; every expected sample pulse is queued when a frame is
// issued and a monitor pops and compares whenever the DUT reports a bit.
module tb_rx_frame_fsm;

    localparam int         DATA_BITS    = 8;
    localparam logic [4:0] ST_IDLE      = 5'b00001;
    localparam logic [4:0] ST_STARTBIT  = 5'b00010;
    localparam logic [4:0] ST_DATABITS  = 5'b00100;
    localparam logic [4:0] ST_PARITYBIT = 5'b01000;
    localparam logic [4:0] ST_STOPBIT   = 5'b10000;
    localparam int         SAMPLE_CNT   = 8;

    typedef struct {
        logic       bit_v;
        logic [4:0] state;
        logic       ferr;
        logic       chk_width;
        logic       has_idx;
        logic [2:0] idx;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rx   = 1'b1;
    logic tick = 1'b0;
    logic pe   = 1'b0;

    int   total       = 0;
    int   bad         = 0;
    int   frame_ticks = 0;
    logic seen_data   = 1'b0;

    exp_t exp_q[$];
    exp_t mon_e;

    rx_frame_fsm_if bus ();

    rx_frame_fsm #(
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_i             (rx),
        .p_BaudTick_i     (tick),
        .p_ParityEnable_i (pe),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Single point where every comparison is counted and reported
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every sample pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && bus.p_BitValid_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected bit pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pulse bit value", bus.Bit_o, mon_e.bit_v);
                checkOutput("pulse state", bus.State_o, mon_e.state);
                checkOutput("pulse frame error", bus.p_FrameError_o, mon_e.ferr);
                if (mon_e.chk_width) begin
                    checkOutput("pulse width count", bus.BitWidthCnt_o, SAMPLE_CNT);
                end
                if (mon_e.has_idx) begin
                    checkOutput("pulse data index", bus.BitCnt_o, mon_e.idx);
                end
            end
        end
    end

    // Hard time limit so the bench always ends
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One baud tick after a gap of g clocks; must be entered at a negedge.
    // The state seen just before the tick is the state the tick acts on.
    task automatic sendTick(input int gap);
        int g;
        g = (gap > 0) ? gap : int'($urandom_range(3, 6));
        repeat (g - 1) @(negedge clk);
        if (bus.State_o != ST_IDLE) frame_ticks++;
        if (bus.State_o == ST_DATABITS) seen_data = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((bus.State_o != ST_IDLE) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, bus.State_o, ST_IDLE);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, " state"}, bus.State_o, ST_IDLE);
        checkOutput({name, " width count"}, bus.BitWidthCnt_o, 0);
        checkOutput({name, " bit count"}, bus.BitCnt_o, 0);
        checkOutput({name, " bit"}, bus.Bit_o, 1);
        checkOutput({name, " valid"}, bus.p_BitValid_o, 0);
        checkOutput({name, " frame error"}, bus.p_FrameError_o, 0);
    endtask

    // Drive one frame: start, data LSB first, optional even parity, stop.
    // first_gap=3 lines the first tick up with the start-edge detection.
    // hold_ticks keeps the stop level on the line afterwards.
    // reset_bit>=0 aborts the frame with reset while that data bit is on.
    task automatic applyStimulus(input logic [7:0] data, input logic par_en,
                                 input logic stop_val, input int first_gap,
                                 input int hold_ticks, input int reset_bit);
        logic line_bits[$];
        exp_t e;
        int   nbits;

        line_bits.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) line_bits.push_back(data[i]);
        if (par_en) line_bits.push_back(^data);
        line_bits.push_back(stop_val);
        nbits = line_bits.size();

        for (int b = 0; b < nbits; b++) begin
            e.bit_v     = line_bits[b];
            e.ferr      = 1'b0;
            e.chk_width = 1'b1;
            e.has_idx   = 1'b0;
            e.idx       = 3'd0;
            if (b == 0) begin
                e.state = ST_STARTBIT;
            end else if (b <= DATA_BITS) begin
                e.state   = ST_DATABITS;
                e.has_idx = 1'b1;
                e.idx     = 3'(b - 1);
            end else if (b == nbits - 1) begin
                e.state = ST_STOPBIT;
                e.ferr  = ~stop_val;
            end else begin
                e.state = ST_PARITYBIT;
            end
            exp_q.push_back(e);
        end

        $display("[TB] frame data=%02h parity=%0d stop=%0d", data, par_en, stop_val);
        frame_ticks = 0;
        pe          = par_en;

        for (int b = 0; b < nbits; b++) begin
            rx = line_bits[b];
            for (int t = 0; t < 16; t++) begin
                if ((reset_bit >= 0) && (b == reset_bit + 1) && (t == 4)) begin
                    checkOutput("state before reset", bus.State_o, ST_DATABITS);
                    checkOutput("bit count before reset", bus.BitCnt_o, reset_bit);
                    #2 rst = 1'b0;
                    #1 checkResetValues("mid-frame reset");
                    exp_q.delete();
                    rx = 1'b1;
                    @(negedge clk);
                    rst = 1'b1;
                    repeat (4) sendTick(0);
                    checkOutput("idle after reset", bus.State_o, ST_IDLE);
                    return;
                end
                sendTick(((b == 0) && (t == 0)) ? first_gap : 0);
                if ((b == 0) && (t == 0) && (first_gap == 3)) begin
                    checkOutput("start entry state", bus.State_o, ST_STARTBIT);
                    checkOutput("start entry count", bus.BitWidthCnt_o, 0);
                end
            end
        end

        repeat (hold_ticks) sendTick(0);
        if (hold_ticks > 0) begin
            checkOutput("idle while line held", bus.State_o, ST_IDLE);
        end
        rx = 1'b1;
        repeat (4) sendTick(0);
        waitIdle("frame returns idle");
        checkOutput("frame tick length", frame_ticks, 16 * nbits);
        checkOutput("all pulses seen", exp_q.size(), 0);
        checkOutput("frame error level", bus.p_FrameError_o, stop_val ? 0 : 1);
    endtask

    // Line low for a few ticks only: the start bit must be rejected
    task automatic applyFalseStart(input int low_ticks);
        exp_t e;
        e.bit_v     = 1'b1;
        e.state     = ST_IDLE;
        e.ferr      = 1'b0;
        e.chk_width = 1'b0;
        e.has_idx   = 1'b0;
        e.idx       = 3'd0;
        exp_q.push_back(e);

        $display("[TB] false start, low for %0d ticks", low_ticks);
        frame_ticks = 0;
        seen_data   = 1'b0;
        rx          = 1'b0;
        repeat (low_ticks) sendTick(0);
        rx = 1'b1;
        repeat (16) sendTick(0);
        checkOutput("false start ticks in start bit", frame_ticks, SAMPLE_CNT);
        checkOutput("false start data entered", seen_data, 0);
        checkOutput("false start pulses seen", exp_q.size(), 0);
        checkOutput("false start idle", bus.State_o, ST_IDLE);
    endtask

    initial begin
        logic [7:0] rnd_data;
        logic       rnd_par;
        logic       rnd_stop;

        repeat (3) @(negedge clk);
        checkResetValues("power-on reset");
        rst = 1'b1;
        repeat (3) sendTick(0);
        checkOutput("idle ignores ticks", bus.BitWidthCnt_o, 0);

        applyStimulus(8'h55, 1'b0, 1'b1, 0, 0, -1);
        applyStimulus(8'hA3, 1'b1, 1'b1, 0, 0, -1);
        applyFalseStart(4);
        applyStimulus(8'h00, 1'b0, 1'b0, 0, 40, -1);
        applyStimulus(8'h96, 1'b0, 1'b1, 3, 0, -1);
        applyStimulus(8'hC3, 1'b0, 1'b1, 0, 0, 4);
        applyStimulus(8'hC3, 1'b0, 1'b1, 0, 0, -1);

        for (int i = 0; i < 12; i++) begin
            rnd_data = 8'($urandom_range(0, 255));
            rnd_par  = 1'($urandom_range(0, 1));
            rnd_stop = ($urandom_range(0, 3) != 0);
            applyStimulus(rnd_data, rnd_par, rnd_stop,
                          ($urandom_range(0, 3) == 0) ? 3 : 0,
                          rnd_stop ? 0 : int'($urandom_range(0, 30)), -1);
            if ($urandom_range(0, 3) == 0) applyFalseStart(int'($urandom_range(1, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_fsm.md
# rx_frame_fsm

Receive-side frame state machine of the UART RX core. Synchronizes the serial line, detects the start edge, times each bit with a 16x oversample counter, and drives the one-hot `State_o` and `BitWidthCnt_o` that the byte-analysis and shift-register stages decode. It also emits one sampled bit per bit period and flags framing errors. It sits between the baud-tick generator and the shift register / byte-analysis stages.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `ACQ_POINT`, default 4'd7: oversample count at which a bit is sampled.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `rx_i` in 1: raw serial line, idle high; asynchronous to `clk`.
- `p_BaudTick_i` in 1: one-clk pulse, 16 per bit period.
- `p_ParityEnable_i` in 1: 1 = a parity bit follows the data bits.
- `State_o` out 5: one-hot state. IDLE=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000.
- `BitWidthCnt_o` out 4: oversample position within the current bit, 0..15.
- `BitCnt_o` out 3: index of the current data bit, 0..DATA_BITS-1.
- `Bit_o` out 1: last sampled line value.
- `p_BitValid_o` out 1: one-clk pulse when `Bit_o` is updated.
- `p_FrameError_o` out 1: stop bit was sampled low.

## Operation
- **Synchronizer.** Two flops (s1, s2) plus a history flop s3; all reset to 1. Falling edge = s3 & ~s2. The sampled line value is s2.
- **Counter.** `BitWidthCnt_o` changes only when `p_BaudTick_i`=1, and holds between ticks.
- **IDLE.** Count = 0, `BitCnt_o` = 0, ticks ignored. On a falling edge: go to STARTBIT with count 0. A tick in the same cycle is consumed by the transition, so the count stays 0.
- **Tick with count == ACQ_POINT, in any state except IDLE.**
  - `Bit_o` <= s2.
  - `p_BitValid_o` = 1 for exactly one clk. This includes the start, parity and stop bits.
- **STARTBIT, tick at ACQ_POINT with s2 = 1 (false start).** Go to IDLE with count 0. `p_BitValid_o` still pulses.
- **Tick with count == 15 (end of bit).** The count wraps to 0 and the state advances:
  - STARTBIT -> DATABITS, with `BitCnt_o` = 0.
  - DATABITS with `BitCnt_o` < DATA_BITS-1: stay in DATABITS, `BitCnt_o`+1.
  - DATABITS with `BitCnt_o` = DATA_BITS-1: go to PARITYBIT if `p_ParityEnable_i`, else STOPBIT.
  - PARITYBIT -> STOPBIT.
  - STOPBIT -> IDLE.
- **Parity enable.** `p_ParityEnable_i` is sampled only at the DATABITS exit decision.
- **Framing error.** In STOPBIT, a tick at ACQ_POINT with s2 = 0 sets `p_FrameError_o` = 1. It holds until the next STARTBIT entry, which clears it.
- **Break condition.** A line held low after a frame error produces no new falling edge, so the FSM stays in IDLE until the line returns high and falls again.
- **Illegal state.** Any non-one-hot state goes to IDLE on the next clk, with counts cleared.
- **Reset values.** State = IDLE, both counters = 0, `Bit_o` = 1, `p_BitValid_o` = 0, `p_FrameError_o` = 0.
- **Reset mid-frame.** Reset forces the reset values immediately. After release, the block waits for a fresh falling edge.

## Timing
- **Start-edge latency.**
  - `rx_i` low captured at edge k.
  - Falling edge visible after edge k+1.
  - `State_o` = STARTBIT after edge k+2.
- All outputs are registered and there is no combinational path from input to output.
- **Bit sample point.** The sample taken at tick with count == ACQ_POINT lands on `Bit_o` and `p_BitValid_o` at the same edge at which the count becomes ACQ_POINT+1 = 8.
- **Downstream decode window.** `State_o` and `BitWidthCnt_o` stay stable for the whole interval between ticks. Downstream stages may decode counts 8, 9 and 10 within the same state.
- **Frame length.** 16 ticks per bit. A full 8N1 frame occupies 160 ticks from STARTBIT entry to IDLE re-entry.

## Structure
- Shared package holds:
  - state encodings `IDLE`/`STARTBIT`/`DATABITS`/`PARITYBIT`/`STOPBIT`;
  - `ACQ_POINT` = 7 and `LAST_CNT` = 15;
  - `WRONG`/`RIGHT` error levels.
- The byte-analysis stage imports the same package.
- Sub-module `rx_line_sync` contains the s1/s2/s3 flops and the falling-edge detect. The rest is one FSM plus two counters in `rx_frame_fsm`.

## Test plan
- **8N1 frame, data 0x55 (LSB first).** Required response:
  - State sequence IDLE->STARTBIT->DATABITS(x8)->STOPBIT->IDLE.
  - 10 `p_BitValid_o` pulses with `Bit_o` = 0,1,0,1,0,1,0,1,0,1.
  - `p_FrameError_o` = 0.
- **Parity enabled, data 0xA3, parity bit 0.** Required response:
  - PARITYBIT is entered after `BitCnt_o` = 7 and 15-count.
  - 11 valid pulses; the parity pulse carries `Bit_o` = 0.
- **False start: `rx_i` low for 4 ticks, then high.** Required response:
  - Returns to IDLE at the tick with count 7.
  - Exactly one valid pulse, with `Bit_o` = 1.
  - DATABITS is never entered.
- **Stop bit driven low, data 0x00.** Required response:
  - `p_FrameError_o` = 1 from the STOPBIT count 8 until the next STARTBIT entry.
  - No new frame starts while the line is held low.
- **Assert `rst` in DATABITS with `BitCnt_o` = 4.** Required response:
  - All outputs take their reset values at once.
  - The next clean frame 0xC3 is received correctly.
- **`p_BaudTick_i` in the same clk as start-edge detection.** Required response:
  - STARTBIT is entered with `BitWidthCnt_o` = 0.
  - The first sample occurs at the 8th subsequent tick.
